// File: rtl/mips_pkg.sv
// mips_pkg -- shared types for the MIPS execute path.
//   reg_addr_t : 5-bit architectural register index
//   alu_op_e   : ALU opcode carried on alu_control
//   op_sel_e   : ALU operand source select
//   fwd_hit()  : forwarding match test (never matches register 0)
package mips_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SLL = 3'd3,
    ALU_SRL = 3'd4,
    ALU_SRA = 3'd5,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_RS_RT    = 2'b00,  // a=rs, b=rt
    OP_RS_IMM   = 2'b01,  // a=rs, b=imm
    OP_RT_SHAMT = 2'b10,  // a=rt, b=shamt (shifts)
    OP_ZERO_IMM = 2'b11   // a=0,  b=imm  (lui-style)
  } op_sel_e;

  // Source operands resolved by the forwarding muxes.
  localparam int NUM_SRC = 2;
  localparam int SRC_RS  = 0;
  localparam int SRC_RT  = 1;

  // $zero is hard-wired, so a write to it must never be forwarded.
  function automatic logic fwd_hit(input logic      we,
                                   input reg_addr_t wr_addr,
                                   input reg_addr_t src_addr);
    return we && (wr_addr != '0) && (wr_addr == src_addr);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux -- resolves one registered source operand against the EX/MEM and
// WB write ports. EX/MEM is younger and wins over WB.
// Macro EX_OPERAND_FORWARD_EN: when undefined the forward inputs are ignored
// and the registered value passes straight through.
// Ports:
//   src_addr, reg_data             : registered source index / value
//   exm_we, exm_addr, exm_data     : EX/MEM write port
//   wb_we,  wb_addr,  wb_data      : WB write port
//   data                           : resolved operand
module fwd_mux
  import mips_pkg::*;
#(
  parameter int Width = 32
) (
  input  reg_addr_t        src_addr,
  input  logic [Width-1:0] reg_data,
  input  logic             exm_we,
  input  reg_addr_t        exm_addr,
  input  logic [Width-1:0] exm_data,
  input  logic             wb_we,
  input  reg_addr_t        wb_addr,
  input  logic [Width-1:0] wb_data,
  output logic [Width-1:0] data
);

`ifdef EX_OPERAND_FORWARD_EN
  always_comb begin
    data = reg_data;
    if (fwd_hit(exm_we, exm_addr, src_addr))
      data = exm_data;
    else if (fwd_hit(wb_we, wb_addr, src_addr))
      data = wb_data;
  end
`else
  assign data = reg_data;

  // Forward ports stay on the interface but carry no meaning in this build.
  logic unused_fwd;
  assign unused_fwd = ^{src_addr, exm_we, exm_addr, exm_data,
                        wb_we, wb_addr, wb_data};
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage -- one-entry ID/EX register with ready/valid handshake,
// operand forwarding and ALU operand selection.
// Macro EX_OPERAND_FORWARD_EN enables EX/MEM and WB forwarding of rs/rt.
// Ports:
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   in_valid_i / in_ready_o         : decode-side handshake
//   rs/rt_data_i, imm_i, shamt_i    : operand sources
//   rs/rt/rd_addr_i                 : register indices
//   alu_control_i, op_sel_i         : ALU opcode and operand select
//   flush_i                         : drop held and incoming bundle
//   exm_*, wb_*                     : forward sources
//   out_valid_o / out_ready_i       : ALU-side handshake
//   a_o, b_o, alu_control_o, rd_addr_o : ALU operands / control
module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] rs_data_i,
  input  logic [Width-1:0] rt_data_i,
  input  logic [Width-1:0] imm_i,
  input  logic [4:0]       shamt_i,
  input  logic [4:0]       rs_addr_i,
  input  logic [4:0]       rt_addr_i,
  input  logic [4:0]       rd_addr_i,
  input  logic [2:0]       alu_control_i,
  input  logic [1:0]       op_sel_i,
  input  logic             flush_i,
  input  logic             exm_we_i,
  input  logic [4:0]       exm_addr_i,
  input  logic [Width-1:0] exm_data_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_addr_i,
  input  logic [Width-1:0] wb_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] a_o,
  output logic [Width-1:0] b_o,
  output logic [2:0]       alu_control_o,
  output logic [4:0]       rd_addr_o
);

  typedef struct packed {
    logic [Width-1:0] rs_data;
    logic [Width-1:0] rt_data;
    logic [Width-1:0] imm;
    logic [4:0]       shamt;
    reg_addr_t        rs_addr;
    reg_addr_t        rt_addr;
    reg_addr_t        rd_addr;
    alu_op_e          alu_op;
    op_sel_e          op_sel;
  } bundle_t;

  bundle_t bnd_d, bnd_q;
  logic    vld_q;
  logic    accept, load;

  assign in_ready_o = !vld_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  // Flush also kills the bundle arriving this cycle.
  assign load       = accept && !flush_i;

  always_comb begin
    bnd_d         = '0;
    bnd_d.rs_data = rs_data_i;
    bnd_d.rt_data = rt_data_i;
    bnd_d.imm     = imm_i;
    bnd_d.shamt   = shamt_i;
    bnd_d.rs_addr = rs_addr_i;
    bnd_d.rt_addr = rt_addr_i;
    bnd_d.rd_addr = rd_addr_i;
    bnd_d.alu_op  = alu_op_e'(alu_control_i);
    bnd_d.op_sel  = op_sel_e'(op_sel_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      bnd_q <= '0;
    end else begin
      if (flush_i)          vld_q <= 1'b0;
      else if (accept)      vld_q <= 1'b1;
      else if (out_ready_i) vld_q <= 1'b0;
      // Fields only move on a real capture, so a stall holds them.
      if (load) bnd_q <= bnd_d;
    end
  end

  assign out_valid_o = vld_q;

  // Forwarding: one mux per source operand.
  reg_addr_t [NUM_SRC-1:0]            src_addr;
  logic      [NUM_SRC-1:0][Width-1:0] src_data;
  logic      [NUM_SRC-1:0][Width-1:0] fwd_data;

  assign src_addr[SRC_RS] = bnd_q.rs_addr;
  assign src_addr[SRC_RT] = bnd_q.rt_addr;
  assign src_data[SRC_RS] = bnd_q.rs_data;
  assign src_data[SRC_RT] = bnd_q.rt_data;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_mux #(.Width(Width)) u_fwd (
      .src_addr (src_addr[g]),
      .reg_data (src_data[g]),
      .exm_we   (exm_we_i),
      .exm_addr (exm_addr_i),
      .exm_data (exm_data_i),
      .wb_we    (wb_we_i),
      .wb_addr  (wb_addr_i),
      .wb_data  (wb_data_i),
      .data     (fwd_data[g])
    );
  end

  // Operand select.
  always_comb begin
    a_o = fwd_data[SRC_RS];
    b_o = fwd_data[SRC_RT];
    unique case (bnd_q.op_sel)
      OP_RS_RT: begin
        a_o = fwd_data[SRC_RS];
        b_o = fwd_data[SRC_RT];
      end
      OP_RS_IMM: begin
        a_o = fwd_data[SRC_RS];
        b_o = bnd_q.imm;
      end
      OP_RT_SHAMT: begin
        a_o = fwd_data[SRC_RT];
        b_o = {{(Width-5){1'b0}}, bnd_q.shamt};
      end
      OP_ZERO_IMM: begin
        a_o = '0;
        b_o = bnd_q.imm;
      end
      default: ;
    endcase
  end

  assign alu_control_o = bnd_q.alu_op;
  assign rd_addr_o     = bnd_q.rd_addr;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

`ifdef EX_OPERAND_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i, exm_data_i, wb_data_i, a_o, b_o;
  logic [4:0]  shamt_i, rs_addr_i, rt_addr_i, rd_addr_i, exm_addr_i, wb_addr_i, rd_addr_o;
  logic [2:0]  alu_control_i, alu_control_o;
  logic [1:0]  op_sel_i;
  logic        exm_we_i, wb_we_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.Width(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .shamt_i(shamt_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .alu_control_i(alu_control_i), .op_sel_i(op_sel_i), .flush_i(flush_i),
    .exm_we_i(exm_we_i), .exm_addr_i(exm_addr_i), .exm_data_i(exm_data_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .a_o(a_o), .b_o(b_o),
    .alu_control_o(alu_control_o), .rd_addr_o(rd_addr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] op, input logic [4:0] rsa, input logic [31:0] rs,
                        input logic [4:0] rta, input logic [31:0] rt, input logic [31:0] imm,
                        input logic [4:0] sh, input logic [2:0] alu, input logic [4:0] rd);
    op_sel_i = op; rs_addr_i = rsa; rs_data_i = rs; rt_addr_i = rta; rt_data_i = rt;
    imm_i = imm; shamt_i = sh; alu_control_i = alu; rd_addr_i = rd;
  endtask

  task automatic clr_fwd();
    exm_we_i = 0; exm_addr_i = 0; exm_data_i = 0;
    wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0;
  endtask

  initial begin
    rst_i = 1; in_valid_i = 0; flush_i = 0; out_ready_i = 1;
    set_in(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 3'd0, 5'd0);
    clr_fwd();
    tick(); tick();
    rst_i = 0;
    #1;
    // Reset state
    chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_a", a_o, 32'd0);
    chk("rst_b", b_o, 32'd0);
    chk("rst_alu", {29'b0, alu_control_o}, 32'd0);
    chk("rst_rd", {27'b0, rd_addr_o}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready_o}, 32'd1);

    // rs + imm, ADD
    set_in(2'b01, 5'd1, 32'd5, 5'd2, 32'd99, 32'd7, 5'd0, 3'd2, 5'd9);
    in_valid_i = 1;
    tick();
    in_valid_i = 0;
    chk("add_valid", {31'b0, out_valid_o}, 32'd1);
    chk("add_a", a_o, 32'd5);
    chk("add_b", b_o, 32'd7);
    chk("add_alu", {29'b0, alu_control_o}, 32'd2);
    chk("add_rd", {27'b0, rd_addr_o}, 32'd9);
    tick();
    chk("add_drain", {31'b0, out_valid_o}, 32'd0);

    // Back-to-back: rs/rt SUB then rt/shamt SRA then lui-style
    set_in(2'b00, 5'd1, 32'h11, 5'd2, 32'h22, 32'h5, 5'd3, 3'd6, 5'd4);
    in_valid_i = 1;
    tick();
    chk("rr_a", a_o, 32'h11);
    chk("rr_b", b_o, 32'h22);
    chk("rr_alu", {29'b0, alu_control_o}, 32'd6);
    set_in(2'b10, 5'd1, 32'h1, 5'd2, 32'h8000_0000, 32'h5, 5'd4, 3'd5, 5'd6);
    tick();
    chk("sra_valid", {31'b0, out_valid_o}, 32'd1);
    chk("sra_a", a_o, 32'h8000_0000);
    chk("sra_b", b_o, 32'd4);
    chk("sra_alu", {29'b0, alu_control_o}, 32'd5);
    set_in(2'b11, 5'd1, 32'hFFFF, 5'd2, 32'h3, 32'h1234, 5'd7, 3'd1, 5'd8);
    tick();
    in_valid_i = 0;
    chk("lui_valid", {31'b0, out_valid_o}, 32'd1);
    chk("lui_a", a_o, 32'd0);
    chk("lui_b", b_o, 32'h1234);
    chk("lui_rd", {27'b0, rd_addr_o}, 32'd8);
    tick();
    chk("lui_drain", {31'b0, out_valid_o}, 32'd0);

    // Forwarding
    out_ready_i = 0;
    set_in(2'b00, 5'd3, 32'h11, 5'd4, 32'h22, 32'h0, 5'd0, 3'd2, 5'd5);
    in_valid_i = 1;
    tick();
    in_valid_i = 0;
    exm_we_i = 1; exm_addr_i = 5'd3; exm_data_i = 32'hAA;
    wb_we_i = 1; wb_addr_i = 5'd3; wb_data_i = 32'hBB;
    #1 chk("fwd_exm_prio", a_o, FWD ? 32'hAA : 32'h11);
    exm_we_i = 0;
    #1 chk("fwd_wb", a_o, FWD ? 32'hBB : 32'h11);
    wb_addr_i = 5'd4;
    #1 chk("fwd_wb_rt", b_o, FWD ? 32'hBB : 32'h22);
    chk("fwd_rs_nomatch", a_o, 32'h11);
    exm_we_i = 1; exm_addr_i = 5'd0; wb_addr_i = 5'd0;
    #1 chk("fwd_addr0_a", a_o, 32'h11);
    chk("fwd_addr0_b", b_o, 32'h22);
    // Source register 0 must not pick up a write to register 0
    out_ready_i = 1;
    set_in(2'b00, 5'd0, 32'h33, 5'd4, 32'h22, 32'h0, 5'd0, 3'd2, 5'd5);
    in_valid_i = 1;
    tick();
    in_valid_i = 0; out_ready_i = 0;
    #1 chk("fwd_zero_src", a_o, 32'h33);
    clr_fwd();
    out_ready_i = 1;
    tick();
    chk("fwd_drain", {31'b0, out_valid_o}, 32'd0);

    // Stall with a waiting bundle
    out_ready_i = 0;
    set_in(2'b01, 5'd1, 32'hA0, 5'd2, 32'h0, 32'hA1, 5'd0, 3'd2, 5'd1);
    in_valid_i = 1;
    tick();
    set_in(2'b01, 5'd1, 32'hB0, 5'd2, 32'h0, 32'hB1, 5'd0, 3'd0, 5'd2);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'b0, in_ready_o}, 32'd0);
      chk("stall_a", a_o, 32'hA0);
      chk("stall_b", b_o, 32'hA1);
      chk("stall_rd", {27'b0, rd_addr_o}, 32'd1);
      tick();
    end
    chk("stall_valid", {31'b0, out_valid_o}, 32'd1);
    out_ready_i = 1;
    #1 chk("release_in_ready", {31'b0, in_ready_o}, 32'd1);
    tick();
    in_valid_i = 0;
    chk("release_valid", {31'b0, out_valid_o}, 32'd1);
    chk("release_a", a_o, 32'hB0);
    chk("release_b", b_o, 32'hB1);
    chk("release_rd", {27'b0, rd_addr_o}, 32'd2);
    tick();
    chk("release_drain", {31'b0, out_valid_o}, 32'd0);

    // Flush drops the incoming bundle
    set_in(2'b01, 5'd1, 32'h77, 5'd2, 32'h0, 32'h78, 5'd0, 3'd2, 5'd3);
    in_valid_i = 1; flush_i = 1;
    #1 chk("flush_in_ready", {31'b0, in_ready_o}, 32'd1);
    tick();
    in_valid_i = 0; flush_i = 0;
    chk("flush_valid", {31'b0, out_valid_o}, 32'd0);
    chk("flush_a_kept", a_o, 32'hB0);
    tick();
    chk("flush_valid2", {31'b0, out_valid_o}, 32'd0);
    // Flush a held, stalled bundle
    out_ready_i = 0;
    set_in(2'b01, 5'd1, 32'h44, 5'd2, 32'h0, 32'h45, 5'd0, 3'd2, 5'd3);
    in_valid_i = 1;
    tick();
    in_valid_i = 0; flush_i = 1;
    tick();
    flush_i = 0;
    chk("flush_held", {31'b0, out_valid_o}, 32'd0);

    // Reset while a bundle is held, with a new bundle offered
    set_in(2'b01, 5'd1, 32'h55, 5'd2, 32'h0, 32'h66, 5'd0, 3'd1, 5'd7);
    in_valid_i = 1;
    tick();
    chk("pre_rst_valid", {31'b0, out_valid_o}, 32'd1);
    chk("pre_rst_a", a_o, 32'h55);
    set_in(2'b01, 5'd1, 32'h99, 5'd2, 32'h0, 32'h98, 5'd0, 3'd7, 5'd6);
    rst_i = 1;
    tick();
    rst_i = 0; in_valid_i = 0;
    chk("rst2_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst2_a", a_o, 32'd0);
    chk("rst2_b", b_o, 32'd0);
    chk("rst2_alu", {29'b0, alu_control_o}, 32'd0);
    chk("rst2_rd", {27'b0, rd_addr_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
